// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one 8N1 UART transmit line between two byte
//               requesters. Arbitrates in IDLE (round-robin or fixed
//               priority on a tie), latches the granted byte and
//               serializes it LSB first, one bit per baud_tick.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               baud_tick          - one-cycle pulse per bit period
//               reqN_valid/data    - channel N byte offer
//               reqN_ready         - channel N byte accepted this cycle
//               tx                 - registered serial line, idle high
//               busy               - a frame is latched or in flight
//               grant_id           - channel of current / last frame
//               frame_done         - one-cycle pulse when the frame ends
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int STOP_BITS   = 1,
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Value of the stop counter on the final stop period (1 or 2 stop bits).
  localparam logic C_LAST_STOP = 1'(STOP_BITS - 1);

  state_t     r_state,      w_state_nxt;
  logic [2:0] r_bit_idx,    w_bit_idx_nxt;
  logic       r_stop_cnt,   w_stop_cnt_nxt;
  logic [7:0] r_data,       w_data_nxt;
  logic       r_tx,         w_tx_nxt;
  logic       r_grant,      w_grant_nxt;
  logic       r_last_grant, w_last_grant_nxt;
  logic       r_frame_done, w_frame_done_nxt;
  logic       w_sel;
  logic       w_can_accept;

  // Channel selection: a lone requester wins; a tie goes to the channel
  // that did not own the last frame, or to channel 0 in fixed priority.
  always_comb begin
    w_sel = req1_valid;
    if (req0_valid && req1_valid) begin
      w_sel = (ROUND_ROBIN != 0) ? ~r_last_grant : 1'b0;
    end
  end

  // Ready is withheld during reset so no byte is acknowledged and then lost.
  assign w_can_accept = (r_state == S_IDLE) && !rst;
  assign req0_ready   = w_can_accept && req0_valid && !w_sel;
  assign req1_ready   = w_can_accept && req1_valid &&  w_sel;

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_idx_nxt    = r_bit_idx;
    w_stop_cnt_nxt   = r_stop_cnt;
    w_data_nxt       = r_data;
    w_tx_nxt         = r_tx;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_frame_done_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A tick in the accept cycle is deliberately ignored: ARM always
        // waits for a later tick so the start bit is a full bit period.
        if (req0_ready || req1_ready) begin
          w_data_nxt       = w_sel ? req1_data : req0_data;
          w_grant_nxt      = w_sel;
          w_last_grant_nxt = w_sel;
          w_state_nxt      = S_ARM;
        end
      end
      S_ARM: begin
        if (baud_tick) begin
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          w_tx_nxt      = r_data[0];
          w_bit_idx_nxt = 3'd0;
          w_state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (r_bit_idx != 3'd7) begin
            w_tx_nxt      = r_data[r_bit_idx + 3'd1];
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end else begin
            w_tx_nxt       = 1'b1;
            w_stop_cnt_nxt = 1'b0;
            w_state_nxt    = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (r_stop_cnt == C_LAST_STOP) begin
            w_state_nxt      = S_IDLE;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit_idx    <= 3'd0;
      r_stop_cnt   <= 1'b0;
      r_data       <= 8'd0;
      r_tx         <= 1'b1;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_stop_cnt   <= w_stop_cnt_nxt;
      r_data       <= w_data_nxt;
      r_tx         <= w_tx_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign grant_id   = r_grant;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Drives two arbiter instances (round-robin / 1 stop bit and
//               fixed priority / 2 stop bits) with directed and random
//               traffic and compares every cycle with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic       tick = 1'b0;
  logic       v0 [2];
  logic       v1 [2];
  logic [7:0] d0 [2];
  logic [7:0] d1 [2];
  logic       r0 [2];
  logic       r1 [2];
  logic       txo [2];
  logic       busyo [2];
  logic       gido [2];
  logic       fdo [2];

  uart_tx_arbiter #(.STOP_BITS(1), .ROUND_ROBIN(1)) dut_a (
    .clk(clk), .rst(rst), .baud_tick(tick),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(r0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(r1[0]),
    .tx(txo[0]), .busy(busyo[0]), .grant_id(gido[0]), .frame_done(fdo[0])
  );

  uart_tx_arbiter #(.STOP_BITS(2), .ROUND_ROBIN(0)) dut_b (
    .clk(clk), .rst(rst), .baud_tick(tick),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(r0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(r1[1]),
    .tx(txo[1]), .busy(busyo[1]), .grant_id(gido[1]), .frame_done(fdo[1])
  );

  int checks = 0;
  int errors = 0;

  // Model configuration per instance.
  int sb_of [2] = '{1, 2};
  bit rr_of [2] = '{1'b1, 1'b0};

  // Frame-level model: a frame is "ticks counted since accept"; the line
  // value follows directly from that count.
  bit         m_busy [2];
  int         m_k    [2];
  logic [7:0] m_byte [2];
  bit         m_gid  [2];
  bit         m_last [2];
  bit         m_fd   [2];
  bit         e_r0   [2];
  bit         e_r1   [2];

  // Stimulus controls.
  bit hold0 = 1'b0;
  bit hold1 = 1'b0;
  bit rnd_mode = 1'b0;
  int tick_period = 4;
  bit tick_force = 1'b0;
  int cyc = 0;

  // Observations for directed checks.
  int glog   [2][$];
  bit txlog  [2][$];
  int fd_tick[2];
  int fdcount[2];
  int r0cnt  [2];
  int r1cnt  [2];

  task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, u, obs, exp);
    end
  endtask

  function automatic bit exp_tx(input int u);
    int k;
    k = m_k[u];
    if (!m_busy[u]) return 1'b1;
    if (k == 1) return 1'b0;
    if (k >= 2 && k <= 9) return m_byte[u][k-2];
    return 1'b1;
  endfunction

  task automatic clear_logs();
    for (int u = 0; u < 2; u++) begin
      glog[u].delete();
      txlog[u].delete();
      fd_tick[u] = 0;
      fdcount[u] = 0;
      r0cnt[u]   = 0;
      r1cnt[u]   = 0;
    end
  endtask

  task automatic cycle();
    bit pre_busy [2];
    bit acc0, acc1, sel;
    @(negedge clk);
    cyc++;
    tick = tick_force
         || (tick_period > 0 && (cyc % tick_period) == 0)
         || (tick_period == 0 && $urandom_range(0, 2) == 0);
    tick_force = 1'b0;
    if (rnd_mode) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int u = 0; u < 2; u++) begin
        if (!v0[u]) begin
          v0[u] = ($urandom_range(0, 3) == 0);
          d0[u] = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) v0[u] = 1'b0;
        if (!v1[u]) begin
          v1[u] = ($urandom_range(0, 3) == 0);
          d1[u] = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) v1[u] = 1'b0;
      end
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      if (v0[u] && v1[u]) sel = rr_of[u] ? !m_last[u] : 1'b0;
      else                sel = v1[u];
      e_r0[u] = !m_busy[u] && !rst && v0[u] && !sel;
      e_r1[u] = !m_busy[u] && !rst && v1[u] &&  sel;
      chk("ready0", u, r0[u], e_r0[u]);
      chk("ready1", u, r1[u], e_r1[u]);
      if (r0[u] === 1'b1) r0cnt[u]++;
      if (r1[u] === 1'b1) r1cnt[u]++;
    end
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      pre_busy[u] = m_busy[u];
      acc0 = e_r0[u];
      acc1 = e_r1[u];
      if (rst) begin
        m_busy[u] = 1'b0; m_k[u] = 0; m_fd[u] = 1'b0;
        m_last[u] = 1'b1; m_gid[u] = 1'b0;
      end else begin
        m_fd[u] = 1'b0;
        if (!m_busy[u]) begin
          if (acc0 || acc1) begin
            m_busy[u] = 1'b1;
            m_k[u]    = 0;
            m_byte[u] = acc1 ? d1[u] : d0[u];
            m_gid[u]  = acc1;
            m_last[u] = acc1;
            glog[u].push_back(acc1 ? 1 : 0);
            if (acc0 && !hold0) v0[u] = 1'b0;
            if (acc1 && !hold1) v1[u] = 1'b0;
          end
        end else if (tick) begin
          m_k[u]++;
          if (m_k[u] == 10 + sb_of[u]) begin
            m_busy[u] = 1'b0;
            m_fd[u]   = 1'b1;
            fdcount[u]++;
          end
        end
      end
      if (tick && pre_busy[u]) txlog[u].push_back(txo[u]);
      if (fdo[u] === 1'b1) fd_tick[u] = txlog[u].size();
      chk("tx", u, txo[u], exp_tx(u));
      chk("busy", u, busyo[u], m_busy[u]);
      chk("grant_id", u, gido[u], m_gid[u]);
      chk("frame_done", u, fdo[u], m_fd[u]);
    end
  endtask

  task automatic do_reset();
    rnd_mode = 1'b0;
    for (int u = 0; u < 2; u++) begin
      v0[u] = 1'b0; v1[u] = 1'b0;
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_logs();
  endtask

  bit exp_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    for (int u = 0; u < 2; u++) begin
      v0[u] = 1'b0; v1[u] = 1'b0; d0[u] = 8'h00; d1[u] = 8'h00;
      m_busy[u] = 1'b0; m_k[u] = 0; m_byte[u] = 8'h00;
      m_gid[u] = 1'b0; m_last[u] = 1'b1; m_fd[u] = 1'b0;
    end
    clear_logs();

    // Reset state.
    cycle();
    do_reset();
    for (int u = 0; u < 2; u++) begin
      chk("reset_tx", u, txo[u], 1'b1);
      chk("reset_busy", u, busyo[u], 1'b0);
      chk("reset_grant", u, gido[u], 1'b0);
    end

    // Single byte on channel 0, tick every 4 cycles.
    tick_period = 4;
    hold0 = 1'b0;
    for (int u = 0; u < 2; u++) begin v0[u] = 1'b1; d0[u] = 8'hA5; end
    for (int n = 0; n < 400 && !(fdcount[0] == 1 && fdcount[1] == 1); n++) cycle();
    chk("single_done", 0, fdcount[0], 1);
    chk("single_done", 1, fdcount[1], 1);
    chk("single_ready_cycles", 0, r0cnt[0], 1);
    chk("single_tx_len", 0, txlog[0].size(), 11);
    for (int i = 0; i < 10 && i < txlog[0].size(); i++)
      chk($sformatf("single_tx_bit%0d", i), 0, txlog[0][i], exp_a5[i]);
    chk("single_fd_tick", 0, fd_tick[0], 11);
    chk("single_grant", 0, gido[0], 1'b0);

    // Tie with both channels permanently valid.
    do_reset();
    tick_period = 2;
    hold0 = 1'b1; hold1 = 1'b1;
    for (int u = 0; u < 2; u++) begin
      v0[u] = 1'b1; d0[u] = 8'h11; v1[u] = 1'b1; d1[u] = 8'h22;
    end
    for (int n = 0; n < 400 && glog[0].size() < 4; n++) cycle();
    chk("tie_frames", 0, glog[0].size(), 4);
    for (int i = 0; i < 4 && i < glog[0].size(); i++)
      chk($sformatf("tie_rr_grant%0d", i), 0, glog[0][i], i % 2);
    chk("tie_rr_ready_cycles", 0, r0cnt[0] + r1cnt[0], glog[0].size());
    chk("tie_fixed_ready1", 1, r1cnt[1], 0);
    chk("tie_fixed_frames_seen", 1, (glog[1].size() > 0) ? 1 : 0, 1);
    for (int i = 0; i < glog[1].size(); i++)
      chk($sformatf("tie_fixed_grant%0d", i), 1, glog[1][i], 0);
    hold0 = 1'b0; hold1 = 1'b0;

    // Two stop bits sending 0x00.
    do_reset();
    tick_period = 3;
    for (int u = 0; u < 2; u++) begin v0[u] = 1'b1; d0[u] = 8'h00; end
    for (int n = 0; n < 400 && fdcount[1] < 1; n++) cycle();
    chk("stop2_done", 1, fdcount[1], 1);
    chk("stop2_tx_len", 1, txlog[1].size(), 12);
    for (int i = 0; i < 11 && i < txlog[1].size(); i++)
      chk($sformatf("stop2_tx_bit%0d", i), 1, txlog[1][i], (i < 9) ? 1'b0 : 1'b1);
    chk("stop2_fd_tick", 1, fd_tick[1], 12);

    // Reset after the third data-bit tick of 0xFF.
    do_reset();
    tick_period = 3;
    for (int u = 0; u < 2; u++) begin v0[u] = 1'b1; d0[u] = 8'hFF; end
    for (int n = 0; n < 400 && m_k[0] < 4; n++) cycle();
    chk("midrst_reached", 0, m_k[0], 4);
    for (int u = 0; u < 2; u++) begin v1[u] = 1'b1; d1[u] = 8'h5A; end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_tx", 0, txo[0], 1'b1);
    chk("midrst_busy", 0, busyo[0], 1'b0);
    chk("midrst_fd", 0, fdo[0], 1'b0);
    cycle();
    chk("midrst_reaccept", 0, r1cnt[0], 1);
    chk("midrst_no_done", 0, fdcount[0], 0);
    for (int n = 0; n < 400 && (m_busy[0] || m_busy[1]); n++) cycle();
    chk("midrst_drain", 0, busyo[0], 1'b0);

    // Tick coincident with the accept cycle.
    do_reset();
    tick_period = 5;
    cyc = 0;
    for (int u = 0; u < 2; u++) begin v0[u] = 1'b1; d0[u] = 8'h3C; end
    tick_force = 1'b1;
    cycle();
    chk("coinc_accepted", 0, r0cnt[0], 1);
    chk("coinc_tx_idle", 0, txo[0], 1'b1);
    chk("coinc_busy", 0, busyo[0], 1'b1);
    for (int n = 0; n < 50 && txlog[0].size() == 0; n++) cycle();
    chk("coinc_first_tick", 0, txlog[0].size(), 1);
    if (txlog[0].size() > 0) chk("coinc_start_bit", 0, txlog[0][0], 1'b0);
    for (int n = 0; n < 400 && (m_busy[0] || m_busy[1]); n++) cycle();

    // Random traffic, random ticks, occasional resets.
    do_reset();
    tick_period = 0;
    rnd_mode = 1'b1;
    for (int n = 0; n < 3000; n++) cycle();
    rnd_mode = 1'b0;
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin v0[u] = 1'b0; v1[u] = 1'b0; end
    tick_period = 2;
    for (int n = 0; n < 400 && (m_busy[0] || m_busy[1]); n++) cycle();
    chk("final_idle", 0, busyo[0], 1'b0);
    chk("final_idle", 1, busyo[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
